fetch_unit: RTL

Parametrised instruction-fetch front end for the next-generation core, replacing the fixed 10-bit PC and hard-wired jump LUT. It holds the program counter, a runtime-writable jump-target table, and a 2-entry fetch queue. The queue feeds the decoder over a valid/ready handshake. It redirects on absolute (LUT) or relative branches resolved by control and reports `done` when the program end has drained.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_queue.sv | 65 ++++++
 rtl/fetch_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the instruction-fetch front end.
//   fetch_state_t : sequencer states (IDLE, RUN, DRAIN, DONE)
//   FETCH_Q_DEPTH : number of entries in the fetch queue
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam int FETCH_Q_DEPTH = 2;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue -- small FIFO holding fetched {pc, instruction} pairs.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i, push_data_i : write one entry at the tail
//   pop_i           : remove the head entry
//   flush_i         : discard all entries (wins over push/pop)
//   count_o         : number of valid entries
//   head_o          : head entry (stale contents when count_o is 0)
// The caller guarantees no push when full without a matching pop and no
// pop when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int W = 19,
  localparam int PTR_W = $clog2(FETCH_Q_DEPTH),
  localparam int CNT_W = $clog2(FETCH_Q_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic [W-1:0]     head_o
);

  logic [W-1:0]     mem_q [FETCH_Q_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_Q_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch front end: program counter, runtime-writable
// jump table, 2-entry fetch queue and a small run/drain/done sequencer.
// Optional feature macro: FETCH_PERF_EN adds saturating cycle and
// instruction counters (parameter CNT_W, ports cyc_cnt/instr_cnt).
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   start                   : pulse, (re)start at START_ADDR
//   imem_addr / imem_data   : combinational instruction ROM interface
//   lut_wr_en/ptr/data      : jump-table write port
//   br_valid/abs/ptr/off    : taken branch (absolute via table or relative)
//   instr_valid/ready/out/pc: decoder handshake and queue head
//   busy                    : sequencer in RUN or DRAIN
//   done                    : program drained, held until start
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          PC_W       = 10,
  parameter int          INSTR_W    = 9,
  parameter int          LUT_DEPTH  = 16,
  parameter int          OFF_W      = 6,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned PROG_END   = (1 << PC_W) - 1,
`ifdef FETCH_PERF_EN
  parameter int          CNT_W      = 16,
`endif
  localparam int         LUT_PTR_W  = $clog2(LUT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_data,
  input  logic                 lut_wr_en,
  input  logic [LUT_PTR_W-1:0] lut_wr_ptr,
  input  logic [PC_W-1:0]      lut_wr_data,
  input  logic                 br_valid,
  input  logic                 br_abs,
  input  logic [LUT_PTR_W-1:0] br_ptr,
  input  logic [OFF_W-1:0]     br_off,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [INSTR_W-1:0]   instr_out,
  output logic [PC_W-1:0]      instr_pc,
  output logic                 busy,
`ifdef FETCH_PERF_EN
  output logic [CNT_W-1:0]     cyc_cnt,
  output logic [CNT_W-1:0]     instr_cnt,
`endif
  output logic                 done
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] END_PC   = PC_W'(PROG_END);
  localparam int              QW       = PC_W + INSTR_W;
  localparam int              QCNT_W   = $clog2(FETCH_Q_DEPTH + 1);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] last_pc_q;
  logic [PC_W-1:0] lut_q [LUT_DEPTH];
  logic [PC_W-1:0] br_target;

  logic              active;
  logic              flush;
  logic              take_branch;
  logic              push;
  logic              pop;
  logic              q_space;
  logic [QCNT_W-1:0] q_count;
  logic [QW-1:0]     q_head;

  assign active      = (state_q == RUN) || (state_q == DRAIN);
  assign take_branch = br_valid && active && !start;
  // Any redirect (restart or branch) empties the queue; the head is hidden
  // in that cycle so the decoder never consumes an entry being discarded.
  assign flush       = start || (br_valid && active);

  assign instr_valid = (q_count != '0) && !flush;
  assign pop         = instr_valid && instr_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign q_space     = (q_count < QCNT_W'(FETCH_Q_DEPTH)) || pop;
  assign push        = (state_q == RUN) && !flush && q_space;

  // Table read is from the registers, so a same-cycle write is not seen.
  assign br_target = br_abs ? lut_q[br_ptr]
                            : last_pc_q + PC_W'($signed(br_off));

  fetch_queue #(
    .W (QW)
  ) u_queue (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (push),
    .push_data_i ({pc_q, imem_data}),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (q_count),
    .head_o      (q_head)
  );

  assign {instr_pc, instr_out} = q_head;
  assign imem_addr = pc_q;
  assign busy      = active;
  assign done      = (state_q == DONE);

  // Next-state / next-PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (start) begin
      state_d = RUN;
      pc_d    = START_PC;
    end else if (take_branch) begin
      state_d = RUN;
      pc_d    = br_target;
    end else begin
      case (state_q)
        RUN: begin
          if (push) begin
            if (pc_q == END_PC) begin
              state_d = DRAIN;
            end else begin
              pc_d = pc_q + PC_W'(1);
            end
          end
        end
        DRAIN: begin
          // No fetches here, so the last pop leaves the queue empty.
          if (pop && (q_count == QCNT_W'(1))) begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      last_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (pop) begin
        last_pc_q <= instr_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_wr_en) begin
      lut_q[lut_wr_ptr] <= lut_wr_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] cyc_cnt_q;
  logic [CNT_W-1:0] instr_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
    end else if (start) begin
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (active && (cyc_cnt_q != '1)) begin
        cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
      end
      if (pop && (instr_cnt_q != '1)) begin
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule
